// File: rtl/systolic_weight_seq_pkg.sv
// systolic_weight_seq_pkg
//   Shared parameters for the systolic weight sequencer: default array
//   geometry, weight-buffer address width and the FSM state encoding.
package systolic_weight_seq_pkg;

  localparam int WSEQ_PE_ROW     = 8;
  localparam int WSEQ_PE_COL     = 8;
  localparam int WSEQ_BIT_ROW_ID = 3;
  localparam int WSEQ_ADDR_W     = 10;

  // state      | meaning
  // ST_IDLE    | waiting for i_Start
  // ST_LOAD    | issuing one weight-buffer read per unstalled cycle
  // ST_DRAIN   | last read in flight, its enable beat goes out
  // ST_DONE    | tile complete, o_Done pulses on the following cycle
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/systolic_weight_seq.sv
// systolic_weight_seq
//   Sequences one weight tile from the weight buffer into a PE_ROW x PE_COL
//   systolic array: PE_ROW reads at base+k, each followed one cycle later
//   by a per-column write enable and row ID for the weight loader.
//   Optional build macro: WSEQ_ROW_REVERSE_EN loads the bottom row first
//   (row(k) = PE_ROW-1-k); addresses are base+k either way.
// Ports
//   CLK, RST          clock, asynchronous active-high reset
//   i_Start           tile request, honoured only in IDLE
//   i_Base_Addr       first buffer address of the tile (captured on start)
//   i_Col_Mask        columns to load (captured on start); zero skips reads
//   i_Stall           buffer not ready, holds the current beat
//   o_Rd_En/o_Rd_Addr weight-buffer read strobe and address
//   o_Systolic_En_ID  target row of the enable beat
//   o_Systolic_En_W   per-column write enable
//   o_Busy            tile in progress
//   o_Done            one-cycle completion pulse
module systolic_weight_seq
  import systolic_weight_seq_pkg::*;
#(
  parameter int PE_ROW     = WSEQ_PE_ROW,
  parameter int PE_COL     = WSEQ_PE_COL,
  parameter int BIT_ROW_ID = WSEQ_BIT_ROW_ID,
  parameter int ADDR_W     = WSEQ_ADDR_W
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  i_Start,
  input  logic [ADDR_W-1:0]     i_Base_Addr,
  input  logic [PE_COL-1:0]     i_Col_Mask,
  input  logic                  i_Stall,
  output logic                  o_Rd_En,
  output logic [ADDR_W-1:0]     o_Rd_Addr,
  output logic [BIT_ROW_ID-1:0] o_Systolic_En_ID,
  output logic [PE_COL-1:0]     o_Systolic_En_W,
  output logic                  o_Busy,
  output logic                  o_Done
);

  logic [1:0]            state_q,  state_d;
  logic [BIT_ROW_ID-1:0] k_q,      k_d;
  logic [ADDR_W-1:0]     base_q,   base_d;
  logic [PE_COL-1:0]     mask_q,   mask_d;
  logic                  rd_en_q,  rd_en_d;
  logic [ADDR_W-1:0]     addr_q,   addr_d;
  logic [BIT_ROW_ID-1:0] row_rd_q, row_rd_d;
  logic [BIT_ROW_ID-1:0] en_id_q,  en_id_d;
  logic [PE_COL-1:0]     en_w_q,   en_w_d;
  logic                  busy_q,   busy_d;
  logic                  done_q,   done_d;
  logic [BIT_ROW_ID-1:0] row_k;

`ifdef WSEQ_ROW_REVERSE_EN
  assign row_k = BIT_ROW_ID'(PE_ROW - 1) - k_q;
`else
  assign row_k = k_q;
`endif

  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    base_d   = base_q;
    mask_d   = mask_q;
    rd_en_d  = 1'b0;
    addr_d   = addr_q;
    row_rd_d = row_rd_q;
    case (state_q)
      ST_IDLE: begin
        if (i_Start) begin
          if (i_Col_Mask != '0) begin
            base_d  = i_Base_Addr;
            mask_d  = i_Col_Mask;
            k_d     = '0;
            state_d = ST_LOAD;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_LOAD: begin
        if (!i_Stall) begin
          rd_en_d  = 1'b1;
          addr_d   = base_q + ADDR_W'(k_q);
          // Row ID travels with the read so the enable beat a cycle later
          // still carries the row of the data it writes.
          row_rd_d = row_k;
          if (k_q == BIT_ROW_ID'(PE_ROW - 1)) begin
            k_d     = '0;
            state_d = ST_DRAIN;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Enable stage lines up with the 1-cycle buffer read latency.
  assign en_w_d  = rd_en_q ? mask_q : '0;
  assign en_id_d = rd_en_q ? row_rd_q : en_id_q;
  // Outputs lag the state by a cycle, so busy covers the start edge
  // itself through the cycle o_Done is presented.
  assign busy_d  = (state_q != ST_IDLE) || i_Start;
  assign done_d  = (state_q == ST_DONE);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      base_q   <= '0;
      mask_q   <= '0;
      rd_en_q  <= 1'b0;
      addr_q   <= '0;
      row_rd_q <= '0;
      en_id_q  <= '0;
      en_w_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      base_q   <= base_d;
      mask_q   <= mask_d;
      rd_en_q  <= rd_en_d;
      addr_q   <= addr_d;
      row_rd_q <= row_rd_d;
      en_id_q  <= en_id_d;
      en_w_q   <= en_w_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign o_Rd_En          = rd_en_q;
  assign o_Rd_Addr        = addr_q;
  assign o_Systolic_En_ID = en_id_q;
  assign o_Systolic_En_W  = en_w_q;
  assign o_Busy           = busy_q;
  assign o_Done           = done_q;

endmodule

// File: tb/tb_systolic_weight_seq.sv
// tb_systolic_weight_seq
//   Scoreboard bench for systolic_weight_seq. Each tile's expected reads,
//   enable beats and completion are derived from the tile rules and pushed
//   into queues with their absolute cycle; a monitor on the falling edge
//   pops and compares whatever the DUT presents.
//   Honours WSEQ_ROW_REVERSE_EN when compiled with the design.
module tb_systolic_weight_seq;

  localparam int PE_ROW     = 8;
  localparam int PE_COL     = 8;
  localparam int BIT_ROW_ID = 3;
  localparam int ADDR_W     = 10;

  logic                  CLK = 1'b0;
  logic                  RST = 1'b1;
  logic                  i_Start = 1'b0;
  logic [ADDR_W-1:0]     i_Base_Addr = '0;
  logic [PE_COL-1:0]     i_Col_Mask = '0;
  logic                  i_Stall = 1'b0;
  logic                  o_Rd_En;
  logic [ADDR_W-1:0]     o_Rd_Addr;
  logic [BIT_ROW_ID-1:0] o_Systolic_En_ID;
  logic [PE_COL-1:0]     o_Systolic_En_W;
  logic                  o_Busy;
  logic                  o_Done;

  systolic_weight_seq dut (
    .CLK(CLK), .RST(RST), .i_Start(i_Start), .i_Base_Addr(i_Base_Addr),
    .i_Col_Mask(i_Col_Mask), .i_Stall(i_Stall), .o_Rd_En(o_Rd_En),
    .o_Rd_Addr(o_Rd_Addr), .o_Systolic_En_ID(o_Systolic_En_ID),
    .o_Systolic_En_W(o_Systolic_En_W), .o_Busy(o_Busy), .o_Done(o_Done)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc = cyc + 1;

  int total = 0;
  int bad = 0;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ev_t;

  ev_t q_rd[$];
  ev_t q_en[$];
  ev_t q_dn[$];
  int  last_id = 0;

  function automatic void chk(string name, longint act, longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic int row_of(int j);
`ifdef WSEQ_ROW_REVERSE_EN
    return PE_ROW - 1 - j;
`else
    return j;
`endif
  endfunction

  // Monitor / scoreboard
  always @(negedge CLK) begin
    ev_t e;
    if (!RST) begin
      if (o_Rd_En) begin
        if (q_rd.size() == 0) chk("unexpected_read", 1, 0);
        else begin
          e = q_rd.pop_front();
          chk("rd_cycle", cyc, e.cyc);
          chk("rd_addr", o_Rd_Addr, e.a);
        end
      end
      if (o_Systolic_En_W != '0) begin
        if (q_en.size() == 0) chk("unexpected_enable", 1, 0);
        else begin
          e = q_en.pop_front();
          chk("en_cycle", cyc, e.cyc);
          chk("en_id", o_Systolic_En_ID, e.a);
          chk("en_w", o_Systolic_En_W, e.b);
          last_id = e.a;
        end
      end else begin
        chk("en_id_hold", o_Systolic_En_ID, last_id);
      end
      if (o_Done) begin
        if (q_dn.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          e = q_dn.pop_front();
          chk("done_cycle", cyc, e.cyc);
          chk("busy_at_done", o_Busy, 1);
        end
      end
    end
  end

  task automatic check_all_zero(string tag);
    chk({tag, "_rd_en"}, o_Rd_En, 0);
    chk({tag, "_rd_addr"}, o_Rd_Addr, 0);
    chk({tag, "_en_id"}, o_Systolic_En_ID, 0);
    chk({tag, "_en_w"}, o_Systolic_En_W, 0);
    chk({tag, "_busy"}, o_Busy, 0);
    chk({tag, "_done"}, o_Done, 0);
  endtask

  // Called at a falling edge with the DUT idle; the start is taken on the
  // next rising edge (cycle s). stl[c] is i_Stall for rising edge s+c.
  // Returns at the falling edge of the o_Done cycle, or after an abort.
  task automatic run_tile(input logic [ADDR_W-1:0] base,
                          input logic [PE_COL-1:0] mask,
                          input logic [63:0] stl,
                          input bit junk_start,
                          input int abort_at);
    int s, c, last, done_off;
    ev_t e;
    s = cyc + 1;
    last = 0;
    if (mask == '0) begin
      done_off = 1;
    end else begin
      c = 1;
      for (int j = 0; j < PE_ROW; j++) begin
        while (stl[c]) c++;
        e.cyc = s + c; e.a = (int'(base) + j) % (1 << ADDR_W); e.b = 0;
        q_rd.push_back(e);
        e.cyc = s + c + 1; e.a = row_of(j); e.b = int'(mask);
        q_en.push_back(e);
        last = c;
        c++;
      end
      done_off = last + 2;
    end
    e.cyc = s + done_off; e.a = 0; e.b = 0;
    q_dn.push_back(e);

    i_Start = 1'b1; i_Base_Addr = base; i_Col_Mask = mask; i_Stall = stl[0];
    @(negedge CLK);
    for (int k = 1; k <= done_off; k++) begin
      if (abort_at != 0 && k == abort_at) begin
        @(posedge CLK);
        #2;
        RST = 1'b1;
        q_rd.delete(); q_en.delete(); q_dn.delete();
        last_id = 0;
        #1;
        check_all_zero("abort");
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0; i_Start = 1'b0; i_Stall = 1'b0;
        return;
      end
      i_Stall = stl[k];
      i_Start = junk_start ? 1'($urandom_range(0, 1)) : 1'b0;
      i_Base_Addr = ADDR_W'($urandom);
      i_Col_Mask = PE_COL'($urandom);
      @(negedge CLK);
    end
    i_Start = 1'b0; i_Stall = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  initial begin
    logic [63:0] stl;
    logic [PE_COL-1:0] m;
    #12;
    check_all_zero("reset");
    @(negedge CLK);
    RST = 1'b0;

    run_tile(10'h010, 8'hFF, 64'h0, 1'b0, 0);
    run_tile(10'h010, 8'hFF, 64'h30, 1'b0, 0);
    run_tile(10'h3FE, 8'h5A, 64'h0, 1'b0, 0);
    run_tile(10'h123, 8'h00, 64'h0, 1'b1, 0);
    run_tile(10'h200, 8'hFF, 64'h0, 1'b1, 0);
    run_tile(10'h100, 8'hA5, 64'h0, 1'b0, 5);
    run_tile(10'h0AB, 8'h3C, 64'h0, 1'b0, 0);

    for (int t = 0; t < 40; t++) begin
      stl = '0;
      for (int b = 0; b < 40; b++) stl[b] = ($urandom_range(0, 3) == 0);
      m = PE_COL'($urandom);
      if ($urandom_range(0, 7) == 0) m = '0;
      run_tile(ADDR_W'($urandom), m, stl, 1'($urandom_range(0, 1)), 0);
      repeat ($urandom_range(0, 3)) begin
        i_Stall = 1'($urandom_range(0, 1));
        @(negedge CLK);
        chk("idle_busy", o_Busy, 0);
      end
      i_Stall = 1'b0;
    end

    repeat (3) @(negedge CLK);
    chk("rd_queue_empty", q_rd.size(), 0);
    chk("en_queue_empty", q_en.size(), 0);
    chk("done_queue_empty", q_dn.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/systolic_weight_seq.md
SYSTOLIC_WEIGHT_SEQ -- requirements
Module: systolic_weight_seq

Interface
REQ-001 Parameter PE_ROW, default 8, number of PE rows (weight beats per tile).
REQ-002 Parameter PE_COL, default 8, number of PE columns (En_W width).
REQ-003 Parameter BIT_ROW_ID, default 3, row-ID width, SHALL equal clog2(PE_ROW).
REQ-004 Parameter ADDR_W, default 10, weight buffer address width.
REQ-005 CLK  input  1  clock, all state on rising edge.
REQ-006 RST  input  1  reset, asynchronous, active-high.
REQ-007 i_Start  input  1  tile-load request, sampled in IDLE only.
REQ-008 i_Base_Addr  input  ADDR_W  first weight-buffer address of tile, captured with i_Start.
REQ-009 i_Col_Mask  input  PE_COL  columns to load, captured with i_Start.
REQ-010 i_Stall  input  1  weight buffer not ready; suppresses read for current cycle.
REQ-011 o_Rd_En  output  1  weight buffer read strobe.
REQ-012 o_Rd_Addr  output  ADDR_W  weight buffer read address.
REQ-013 o_Systolic_En_ID  output  BIT_ROW_ID  target row ID, to weight loader.
REQ-014 o_Systolic_En_W  output  PE_COL  per-column write enable, to weight loader.
REQ-015 o_Busy  output  1  high from accepted start through DONE state.
REQ-016 o_Done  output  1  one-cycle pulse on tile completion.

Function
REQ-017 FSM states IDLE, LOAD, DRAIN, DONE; all outputs registered.
REQ-018 IDLE: i_Start=1 with i_Col_Mask!=0 -> capture base/mask, beat counter k=0, go LOAD.
REQ-019 IDLE: i_Start=1 with i_Col_Mask==0 -> go DONE directly, no reads issued.
REQ-020 LOAD, i_Stall=0: next cycle o_Rd_En=1, o_Rd_Addr=base+k (mod 2^ADDR_W), k increments.
REQ-021 LOAD, i_Stall=1: next cycle o_Rd_En=0, k and o_Rd_Addr hold.
REQ-022 LOAD exits to DRAIN on the unstalled beat with k=PE_ROW-1; exactly PE_ROW reads per tile.
REQ-023 Enable alignment: o_Systolic_En_W=mask and o_Systolic_En_ID=row(k) exactly one cycle after the o_Rd_En=1 cycle for beat k (buffer read latency 1).
REQ-024 Cycles not following a read: o_Systolic_En_W=0, o_Systolic_En_ID holds last value.
REQ-025 DRAIN lasts 1 cycle (last enable beat issued), then DONE.
REQ-026 DONE lasts 1 cycle: o_Done=1, o_Busy=1; then IDLE, o_Busy=0.
REQ-027 i_Start ignored outside IDLE; back-to-back tiles: start accepted the cycle after DONE.
REQ-028 Unstalled tile latency: start accepted at cycle 0 -> reads cycles 1..PE_ROW, enables cycles 2..PE_ROW+1, o_Done cycle PE_ROW+2.
REQ-029 i_Stall during DRAIN/DONE/IDLE has no effect.

Reset
REQ-030 RST=1 forces IDLE, k=0, all outputs 0, captured base/mask 0, asynchronously, including mid-tile; no o_Done for aborted tile.
REQ-031 First i_Start is accepted in the first clock edge after RST deasserts.

Configuration
REQ-032 Macro WSEQ_ROW_REVERSE_EN defined: row(k)=PE_ROW-1-k (bottom row first).
REQ-033 Macro WSEQ_ROW_REVERSE_EN undefined: row(k)=k; addresses base+k in both cases.

Structure
REQ-034 PE_ROW, PE_COL, BIT_ROW_ID, ADDR_W defaults and FSM state encoding live in the shared param include.
REQ-035 Single module; beat counter and 1-cycle enable-align stage inline, no sub-module.

Verification
REQ-036 Start base=0x010 mask=0xFF, no stall -> reads 0x010..0x017 cycles 1-8, En_ID 0..7 with En_W=0xFF cycles 2-9, o_Done cycle 10.
REQ-037 Same start, i_Stall=1 on beat 3 for 2 cycles -> 2 gap cycles with En_W=0, still 8 reads, o_Done cycle 12.
REQ-038 Base=0x3FE (ADDR_W=10) -> addresses 0x3FE,0x3FF,0x000..0x005.
REQ-039 Mask=0x00 -> no o_Rd_En, o_Done one cycle after start; start while busy -> ignored, single o_Done.
REQ-040 RST asserted at beat 4 -> all outputs 0 immediately, no o_Done; new start after release runs full tile.
REQ-041 With WSEQ_ROW_REVERSE_EN -> En_ID sequence 7..0, addresses unchanged.
